// File: rtl/button_event_unit.sv
// button_event_unit: AHB-Lite slave that debounces NUM_BTN active-low buttons,
// classifies each press as short or long, and queues the events in a FIFO
// that software drains through the EVENT register.
module button_event_unit #(
    parameter int NUM_BTN      = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int DEB_DEFAULT  = 900,
    parameter int LONG_DEFAULT = 16000
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [31:0]        HADDR,
    input  logic [31:0]        HWDATA,
    input  logic               HWRITE,
    input  logic               HREADY,
    input  logic               HSEL,
    input  logic [2:0]         HSIZE,
    input  logic [1:0]         HTRANS,
    input  logic [NUM_BTN-1:0] nBtn,
    output logic [31:0]        HRDATA,
    output logic               HREADYOUT,
    output logic               IRQ
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_DEB, S_HELD, S_LHELD} btn_state_t;

    // Saturating 16-bit increment for the press counters
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A threshold of 0 behaves as 1
    function automatic logic [15:0] min_one(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [2:0]         addr_q;
    logic               wr_q, vld_q;
    logic               en_q, ie_q, ovf_q, ovf_d;
    logic [15:0]        deb_q, long_q, deb_thr, long_thr;
    btn_state_t         state_q [NUM_BTN];
    btn_state_t         state_d [NUM_BTN];
    logic [15:0]        cnt_q   [NUM_BTN];
    logic [15:0]        cnt_d   [NUM_BTN];
    logic [NUM_BTN-1:0] ev_set, ev_long, dup;
    logic [NUM_BTN-1:0] pend_q, pend_d, pend_long_q, pend_long_d, grant;
    logic               push_req, push_long, found;
    logic [2:0]         push_idx;
    logic [3:0]         mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wptr_q, rptr_q;
    logic [CW-1:0]      count_q;
    logic               full, empty, pop, push_ok, drop, flush;
    logic               wr_en, wr_ctrl, wr_deb, wr_long, rd_event;
    logic               unused_ok;

    assign unused_ok = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA[31:16]};

    assign HREADYOUT = 1'b1;
    assign deb_thr   = min_one(deb_q);
    assign long_thr  = min_one(long_q);

    assign wr_en    = vld_q && wr_q;
    assign wr_ctrl  = wr_en && (addr_q == 3'd2);
    assign wr_deb   = wr_en && (addr_q == 3'd3);
    assign wr_long  = wr_en && (addr_q == 3'd4);
    assign rd_event = vld_q && !wr_q && (addr_q == 3'd1);
    assign flush    = wr_ctrl && HWDATA[2];

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign pop     = rd_event && !empty;
    assign push_ok = push_req && (!full || pop) && !flush;
    assign drop    = push_req && full && !pop && !flush;
    assign ovf_d   = flush ? 1'b0 : (ovf_q | drop | (|dup));
    assign IRQ     = ie_q && !empty;

    // Two-flop synchroniser, idle-high so reset looks like released buttons
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= nBtn;
            sync2_q <= sync1_q;
        end
    end

    // Capture the AHB address phase for use in the following data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            vld_q  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
        end else if (HREADY) begin
            vld_q  <= HSEL && (HTRANS != 2'b00);
            wr_q   <= HWRITE;
            addr_q <= HADDR[4:2];
        end
    end

    // Software-visible configuration and the sticky overflow flag
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            en_q   <= 1'b1;
            ie_q   <= 1'b0;
            ovf_q  <= 1'b0;
            deb_q  <= 16'(DEB_DEFAULT);
            long_q <= 16'(LONG_DEFAULT);
        end else begin
            ovf_q <= ovf_d;
            if (wr_ctrl) begin
                en_q <= HWDATA[0];
                ie_q <= HWDATA[1];
            end
            if (wr_deb)  deb_q  <= HWDATA[15:0];
            if (wr_long) long_q <= HWDATA[15:0];
        end
    end

    // Per-button state and counter registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Debounce and short/long classification; >= lets a lowered threshold
    // take effect at once instead of being skipped past by a running count
    always_comb begin
        ev_set  = '0;
        ev_long = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!en_q) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    S_IDLE: if (!sync2_q[i]) begin
                        state_d[i] = S_DEB;
                        cnt_d[i]   = 16'd1;
                    end
                    S_DEB: if (sync2_q[i]) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] >= deb_thr) begin
                        state_d[i] = S_HELD;
                        cnt_d[i]   = 16'd1;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                    S_HELD: if (sync2_q[i]) begin
                        ev_set[i]  = 1'b1;
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] >= long_thr) begin
                        ev_set[i]  = 1'b1;
                        ev_long[i] = 1'b1;
                        state_d[i] = S_LHELD;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                    S_LHELD: if (sync2_q[i]) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end
                    default: begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Fixed-priority arbiter: lowest pending button index is pushed
    always_comb begin
        grant     = '0;
        found     = 1'b0;
        push_idx  = '0;
        push_long = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (pend_q[i] && !found) begin
                grant[i]  = 1'b1;
                found     = 1'b1;
                push_idx  = 3'(i);
                push_long = pend_long_q[i];
            end
        end
        push_req = found;
    end

    // Pending flags: cleared on grant, set by new events, duplicates dropped
    always_comb begin
        pend_d      = pend_q & ~grant;
        pend_long_d = pend_long_q;
        dup         = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (ev_set[i]) begin
                if (pend_d[i]) begin
                    dup[i] = 1'b1;
                end else begin
                    pend_d[i]      = 1'b1;
                    pend_long_d[i] = ev_long[i];
                end
            end
        end
        if (!en_q) pend_d = '0;
    end

    // Pending flag registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q      <= '0;
            pend_long_q <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_long_q <= pend_long_d;
        end
    end

    // FIFO pointers and occupancy; FLUSH overrides any push or pop
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage holds {long, index}
    always_ff @(posedge HCLK) begin
        if (push_ok) mem_q[wptr_q] <= {push_long, push_idx};
    end

    // Read data mux driven from the registered address phase
    always_comb begin
        HRDATA = '0;
        if (vld_q && !wr_q) begin
            case (addr_q)
                3'd0: begin
                    HRDATA[0]   = !empty;
                    HRDATA[1]   = full;
                    HRDATA[2]   = ovf_q;
                    HRDATA[7:4] = 4'(count_q);
                end
                3'd1: if (!empty) begin
                    HRDATA[31]  = 1'b1;
                    HRDATA[8]   = mem_q[rptr_q][3];
                    HRDATA[2:0] = mem_q[rptr_q][2:0];
                end
                3'd2: begin
                    HRDATA[0] = en_q;
                    HRDATA[1] = ie_q;
                end
                3'd3:    HRDATA[15:0] = deb_q;
                3'd4:    HRDATA[15:0] = long_q;
                default: HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_unit.sv
// Bench for button_event_unit: directed scenarios plus randomized presses,
// checked against a run-length/queue reference model of the button rules.
module tb_button_event_unit;

    localparam int NB    = 4;
    localparam int DEPTH = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [31:0]   HADDR = '0, HWDATA = '0;
    logic          HWRITE = 1'b0, HREADY = 1'b1, HSEL = 1'b0;
    logic [2:0]    HSIZE = 3'b010;
    logic [1:0]    HTRANS = 2'b00;
    logic [NB-1:0] nBtn = '1;
    logic [31:0]   HRDATA;
    logic          HREADYOUT, IRQ;

    int checks = 0;
    int errors = 0;

    button_event_unit #(.NUM_BTN(NB), .FIFO_DEPTH(DEPTH), .DEB_DEFAULT(900),
                        .LONG_DEFAULT(16000)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .nBtn(nBtn), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    // ---------------- reference model ----------------
    logic [NB-1:0] m_h1, m_h2;
    int  m_run [NB];
    bit  m_pend [NB], m_pl [NB], m_ev [NB], m_evl [NB];
    int  m_q [$];
    bit  m_ovf, m_en, m_ie, m_vld, m_wr, m_dup, m_flush, m_pop;
    int  m_deb, m_lng, m_addr, m_g, m_de, m_le;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_h1 = '1; m_h2 = '1;
            for (int i = 0; i < NB; i++) begin
                m_run[i] = 0; m_pend[i] = 0; m_pl[i] = 0;
            end
            m_q.delete();
            m_ovf = 0; m_en = 1; m_ie = 0; m_vld = 0; m_wr = 0; m_addr = 0;
            m_deb = 900; m_lng = 16000;
        end else begin
            m_de = (m_deb == 0) ? 1 : m_deb;
            m_le = (m_lng == 0) ? 1 : m_lng;
            // a press is accepted after de+1 low samples; long after le more
            for (int i = 0; i < NB; i++) begin
                m_ev[i] = 0; m_evl[i] = 0;
                if (!m_en) m_run[i] = 0;
                else if (m_h2[i] == 1'b0) begin
                    m_run[i]++;
                    if (m_run[i] == m_de + 1 + m_le) begin m_ev[i] = 1; m_evl[i] = 1; end
                end else begin
                    if (m_run[i] >= m_de + 1 && m_run[i] < m_de + 1 + m_le) m_ev[i] = 1;
                    m_run[i] = 0;
                end
            end
            m_pop   = m_vld && !m_wr && m_addr == 1 && m_q.size() > 0;
            m_flush = m_vld && m_wr && m_addr == 2 && HWDATA[2];
            m_g = -1;
            for (int i = NB - 1; i >= 0; i--) if (m_pend[i]) m_g = i;
            if (m_flush) begin
                m_q.delete(); m_ovf = 0;
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_g >= 0) begin
                    if (m_q.size() < DEPTH) m_q.push_back(m_g + (m_pl[m_g] ? 256 : 0));
                    else m_ovf = 1;
                end
            end
            if (m_g >= 0) m_pend[m_g] = 0;
            m_dup = 0;
            for (int i = 0; i < NB; i++) if (m_ev[i]) begin
                if (m_pend[i]) m_dup = 1;
                else begin m_pend[i] = 1; m_pl[i] = m_evl[i]; end
            end
            if (m_dup && !m_flush) m_ovf = 1;
            if (!m_en) for (int i = 0; i < NB; i++) m_pend[i] = 0;
            if (m_vld && m_wr) begin
                case (m_addr)
                    2: begin m_en = HWDATA[0]; m_ie = HWDATA[1]; end
                    3: m_deb = int'(HWDATA[15:0]);
                    4: m_lng = int'(HWDATA[15:0]);
                    default: ;
                endcase
            end
            m_vld  = HSEL && HREADY && HTRANS != 2'b00;
            m_wr   = HWRITE;
            m_addr = int'(HADDR[4:2]);
            m_h2 = m_h1; m_h1 = nBtn;
        end
    end

    function automatic logic [31:0] exp_rd(int a);
        logic [31:0] r;
        int n;
        r = '0;
        n = m_q.size();
        case (a)
            0: r = ((n & 15) << 4) | (m_ovf << 2) | ((n == DEPTH) << 1) | (n > 0);
            1: if (n > 0) r = 32'h8000_0000 | m_q[0];
            2: r = (m_ie << 1) | m_en;
            3: r = m_deb;
            4: r = m_lng;
            default: r = '0;
        endcase
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(negedge HCLK);
            chk("irq", {31'b0, IRQ}, {31'b0, m_ie && m_q.size() > 0});
        end
    endtask

    task automatic wr(int a, logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'(a * 4);
        @(negedge HCLK);
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
    endtask

    task automatic rd(int a, string tag, output logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'(a * 4);
        @(negedge HCLK);
        HSEL = 0; HTRANS = 2'b00;
        d = HRDATA;
        chk(tag, HRDATA, exp_rd(a));
    endtask

    task automatic press(int b, int len, int gap);
        nBtn[b] = 1'b0;
        cyc(len);
        nBtn[b] = 1'b1;
        cyc(gap);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] d;
    int len [NB];

    initial begin
        HRESETn = 1'b1;
        #1 HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;

        // reset values
        chk("hreadyout", {31'b0, HREADYOUT}, 32'd1);
        chk("irq_rst", {31'b0, IRQ}, 32'd0);
        chk("hrdata_idle", HRDATA, 32'd0);
        rd(2, "ctrl_rst", d);   chk("ctrl_rst_c", d, 32'h1);
        rd(3, "deb_rst", d);    chk("deb_rst_c", d, 32'd900);
        rd(4, "long_rst", d);   chk("long_rst_c", d, 32'd16000);
        rd(0, "stat_rst", d);   chk("stat_rst_c", d, 32'h0);
        rd(1, "event_empty", d);
        rd(5, "unmapped", d);   chk("unmapped_c", d, 32'h0);

        wr(3, 32'd4);
        wr(4, 32'd20);

        // short press on button 1
        press(1, 12, 8);
        rd(0, "stat_short", d); chk("stat_short_c", d, 32'h11);
        rd(1, "ev_short", d);   chk("ev_short_c", d, 32'h8000_0001);
        rd(0, "stat_pop", d);   chk("stat_pop_c", d, 32'h0);

        // long press on button 2
        press(2, 40, 8);
        rd(1, "ev_long", d);    chk("ev_long_c", d, 32'h8000_0102);
        rd(0, "stat_long", d);  chk("stat_long_c", d, 32'h0);

        // glitches shorter than the debounce window
        wr(2, 32'h3);
        for (int k = 0; k < 5; k++) press(0, 3, 3);
        cyc(5);
        rd(0, "stat_glitch", d); chk("stat_glitch_c", d, 32'h0);

        // simultaneous release on buttons 0 and 3
        nBtn[0] = 1'b0; nBtn[3] = 1'b0;
        cyc(10);
        nBtn[0] = 1'b1; nBtn[3] = 1'b1;
        cyc(8);
        rd(1, "ev_pair0", d); chk("ev_pair0_c", d, 32'h8000_0000);
        rd(1, "ev_pair3", d); chk("ev_pair3_c", d, 32'h8000_0003);

        // overflow then flush
        for (int k = 0; k < 5; k++) press(0, 8, 6);
        rd(0, "stat_full", d);  chk("stat_full_c", d, 32'h47);
        wr(2, 32'h5);
        rd(0, "stat_flush", d); chk("stat_flush_c", d, 32'h0);
        wr(2, 32'h3);

        // randomized presses, drained and compared against the model
        for (int it = 0; it < 30; it++) begin
            if (it % 5 == 0) begin
                wr(3, 32'($urandom_range(0, 5)));
                wr(4, 32'($urandom_range(1, 15)));
            end
            for (int b = 0; b < NB; b++) begin
                len[b] = $urandom_range(0, 22);
                if (len[b] > 0) nBtn[b] = 1'b0;
            end
            for (int t = 1; t <= 22; t++) begin
                cyc(1);
                for (int b = 0; b < NB; b++) if (len[b] == t) nBtn[b] = 1'b1;
            end
            cyc(6);
            for (int k = 0; k < 8; k++) begin
                rd(0, "rnd_stat", d);
                if (m_q.size() == 0) break;
                rd(1, "rnd_event", d);
            end
            if ($urandom_range(0, 7) == 0) wr(2, 32'h7);
        end

        // pop coinciding with a push, then reset mid-hold
        wr(2, 32'h7);
        wr(3, 32'd4);
        wr(4, 32'd20);
        press(1, 12, 8);
        chk("irq_one", {31'b0, IRQ}, 32'd1);
        nBtn[2] = 1'b0;
        cyc(10);
        nBtn[2] = 1'b1;
        cyc(1);
        rd(1, "ev_coincide", d); chk("ev_coincide_c", d, 32'h8000_0001);
        rd(0, "stat_coincide", d); chk("stat_coincide_c", d, 32'h11);
        chk("irq_still", {31'b0, IRQ}, 32'd1);

        nBtn[3] = 1'b0;
        cyc(15);
        #2 HRESETn = 1'b0;
        #1 chk("irq_async_rst", {31'b0, IRQ}, 32'd0);
        cyc(2);
        HRESETn = 1'b1;
        rd(2, "ctrl_rst2", d); chk("ctrl_rst2_c", d, 32'h1);
        rd(3, "deb_rst2", d);  chk("deb_rst2_c", d, 32'd900);
        rd(4, "long_rst2", d); chk("long_rst2_c", d, 32'd16000);
        rd(0, "stat_rst2", d); chk("stat_rst2_c", d, 32'h0);
        cyc(60);
        nBtn[3] = 1'b1;
        cyc(10);
        rd(0, "stat_after_rst", d); chk("stat_after_rst_c", d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
